// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone pipelined initiator that runs one single-beat transfer per command, retrying a bounded number of times.
// Latency: with no stall and an ack in the cycle after the strobe is accepted, rsp_valid_o is high 3 cycles after the command accept edge.
// Backpressure: cmd_ready_o is high only in IDLE, and wb_stall_i holds the strobe. Defining WB_MASTER_TIMEOUT_EN adds a watchdog on wb_cyc_o.
module wb_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [3:0]            cmd_sel_i,
    input  logic [31:0]           cmd_dat_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i,
    input  logic [31:0]           wb_dat_i
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, BACKOFF, RESP} state_t;

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    state_t                  state, nxt_state;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [3:0]              sel_q;
    logic [31:0]             dat_q;
    logic [3:0]              retry_cnt;
    logic [31:0]             rsp_dat_q;
    logic                    rsp_err_q;
    logic                    rsp_to_q;
    logic                    done;
    logic                    done_err;
    logic                    done_to;
    logic [31:0]             done_dat;
    logic                    retry_inc;
    logic                    timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;

    // Cleared in the cycles before REQ is entered, so the first REQ cycle counts as cycle 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt <= '0;
        end else if (state == IDLE || state == BACKOFF) begin
            to_cnt <= '0;
        end else if (wb_cyc_o && to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = wb_cyc_o && (to_cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // A strobe that is not stalled may be terminated in the same cycle, so REQ shares the WAIT decode.
    always_comb begin
        nxt_state = state;
        done      = 1'b0;
        done_err  = 1'b0;
        done_to   = 1'b0;
        done_dat  = '0;
        retry_inc = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid_i) nxt_state = REQ;
            end
            REQ, WAIT: begin
                if (state == WAIT || !wb_stall_i) begin
                    if (wb_err_i) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                    end else if (wb_ack_i) begin
                        done     = 1'b1;
                        done_dat = we_q ? 32'h0 : wb_dat_i;
                    end else if (wb_rty_i) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_inc = 1'b1;
                            nxt_state = BACKOFF;
                        end else begin
                            done     = 1'b1;
                            done_err = 1'b1;
                        end
                    end else if (timeout_hit) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                        done_to  = 1'b1;
                    end else begin
                        nxt_state = WAIT;
                    end
                end else if (timeout_hit) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    done_to  = 1'b1;
                end
                if (done) nxt_state = RESP;
            end
            BACKOFF: nxt_state = REQ;
            RESP:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state == IDLE);
        wb_cyc_o    = (state == REQ) || (state == WAIT);
        wb_stb_o    = (state == REQ);
        rsp_valid_o = (state == RESP);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            retry_cnt <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_to_q  <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid_i) begin
                we_q      <= cmd_we_i;
                adr_q     <= cmd_adr_i;
                sel_q     <= cmd_sel_i;
                dat_q     <= cmd_dat_i;
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
            if (done) begin
                rsp_dat_q <= done_dat;
                rsp_err_q <= done_err;
                rsp_to_q  <= done_to;
            end
        end
    end

    assign wb_we_o       = we_q;
    assign wb_adr_o      = adr_q;
    assign wb_sel_o      = sel_q;
    assign wb_dat_o      = dat_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign rsp_err_o     = rsp_valid_o & rsp_err_q;
    assign rsp_timeout_o = rsp_valid_o & rsp_to_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: a scripted WB responder, plus a scoreboard that checks every response pulse.
// Build with WB_MASTER_TIMEOUT_EN defined to exercise the watchdog, which runs with TIMEOUT_CYCLES=16.
module tb_wb_cmd_master;

    localparam int T_HANG   = 0;
    localparam int T_ACK    = 1;
    localparam int T_ERR    = 2;
    localparam int T_RTY    = 3;
    localparam int T_ERRACK = 4;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        to;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_adr_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0, wb_stall_i = 1'b0;
    logic [31:0] wb_dat_i = '0;

    int vectors = 0;
    int miscompares = 0;
    int cyc_cnt = 0;
    int accept_cyc = 0;

    exp_t exp_q[$];
    int   term_q[$];

    // Responder configuration and observations.
    int          stall_cfg = 0;
    int          stall_left = 0;
    logic [31:0] rd_data = '0;
    logic        stray = 1'b0;
    logic        accepted = 1'b0;
    logic        prev_stb = 1'b0;
    logic        prev_rsp = 1'b0;
    logic        inflight = 1'b0;
    int          stb_cycles = 0, phases = 0, gap_cycles = 0, cyc_high = 0;
    logic [31:0] lat_adr = '0, lat_dat = '0;
    logic [3:0]  lat_sel = '0;
    logic        lat_we = 1'b0;

    wb_cmd_master #(.ADDR_WIDTH(32), .MAX_RETRY(3), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    // Responder: decides the bus inputs for the coming edge from the outputs seen at the falling edge.
    initial begin
        int code;
        forever begin
            @(negedge clk_i);
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0;
            wb_dat_i = 32'hBAD0_BAD0;
            if (!rst_n_i) begin
                accepted = 1'b0;
                stall_left = stall_cfg;
            end else if (wb_cyc_o && wb_stb_o && !accepted) begin
                stb_cycles++;
                if (!prev_stb) phases++;
                if (stall_left > 0) begin
                    wb_stall_i = 1'b1;
                    stall_left--;
                end else begin
                    accepted = 1'b1;
                    lat_adr = wb_adr_o; lat_dat = wb_dat_o; lat_sel = wb_sel_o; lat_we = wb_we_o;
                end
            end else if (wb_cyc_o && accepted) begin
                if (term_q.size() > 0 && term_q[0] != T_HANG) begin
                    code = term_q.pop_front();
                    case (code)
                        T_ACK:    begin wb_ack_i = 1'b1; wb_dat_i = rd_data; end
                        T_ERR:    wb_err_i = 1'b1;
                        T_RTY:    wb_rty_i = 1'b1;
                        T_ERRACK: begin wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = rd_data; end
                        default:  ;
                    endcase
                    accepted = 1'b0;
                    stall_left = stall_cfg;
                end
            end else if (stray && !wb_cyc_o) begin
                wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rty_i = 1'b1;
            end
            prev_stb = wb_stb_o;
        end
    end

    // Scoreboard: every response pulse must match the oldest expectation and last a single cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i && rsp_valid_o) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected: got rsp_valid_o=1 dat=%h, required no response", rsp_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_dat_o, rsp_err_o, rsp_timeout_o, prev_rsp} !== {e.dat, e.err, e.to, 1'b0}) begin
                        miscompares++;
                        $display("FAIL rsp_fields: got dat=%h err=%b to=%b prev_valid=%b, required dat=%h err=%b to=%b prev_valid=0",
                                 rsp_dat_o, rsp_err_o, rsp_timeout_o, prev_rsp, e.dat, e.err, e.to);
                    end
                end
                inflight = 1'b0;
            end
            if (inflight && !wb_cyc_o && !rsp_valid_o) gap_cycles++;
            if (inflight && wb_cyc_o) cyc_high++;
            prev_rsp = rsp_valid_o;
        end
    end

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic [31:0] e_dat, input logic e_err,
                            input logic e_to);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk_i);
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        vectors++;
        if (cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_ready_wait: got cmd_ready_o=%b, required 1", cmd_ready_o);
        end
        stb_cycles = 0; phases = 0; gap_cycles = 0; cyc_high = 0;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat;
        e.dat = e_dat; e.err = e_err; e.to = e_to;
        exp_q.push_back(e);
        accept_cyc = cyc_cnt;
        @(posedge clk_i);
        inflight = 1'b1;
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < 200) begin
            @(negedge clk_i);
            n++;
            if (rsp_valid_o) begin
                lat = cyc_cnt - accept_cyc;
                break;
            end
        end
        vectors++;
        if (lat < 0) begin
            miscompares++;
            $display("FAIL rsp_timeout_wait: got no rsp_valid_o in 200 cycles, required a response");
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        vectors++;
        if ({cmd_ready_o, wb_cyc_o, wb_stb_o, rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy/cyc/stb/vld/err/to=%b, required 100000",
                     {cmd_ready_o, wb_cyc_o, wb_stb_o, rsp_valid_o, rsp_err_o, rsp_timeout_o});
        end
        vectors++;
        if ({rsp_dat_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got rsp_dat=%h adr=%h dat=%h sel=%h we=%b, required all 0",
                     rsp_dat_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o);
        end
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_write_stall();
        int lat;
        stall_cfg = 2; stall_left = 2;
        term_q.push_back(T_ACK);
        send_cmd(1'b1, 32'h8, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        wait_rsp(lat);
        vectors++;
        if (stb_cycles !== 3) begin
            miscompares++;
            $display("FAIL write_stb_cycles: got %0d, required 3", stb_cycles);
        end
        vectors++;
        if ({lat_we, lat_adr, lat_sel, lat_dat} !== {1'b1, 32'h8, 4'hF, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL write_bus_fields: got we=%b adr=%h sel=%h dat=%h, required 1 00000008 f deadbeef",
                     lat_we, lat_adr, lat_sel, lat_dat);
        end
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL write_latency: got %0d, required 5", lat);
        end
        stall_cfg = 0; stall_left = 0;
    endtask

    task automatic test_read();
        int lat;
        rd_data = 32'h12345678;
        term_q.push_back(T_ACK);
        send_cmd(1'b0, 32'h4, 4'hF, 32'h0, 32'h12345678, 1'b0, 1'b0);
        wait_rsp(lat);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL read_latency: got %0d, required 3", lat);
        end
        @(negedge clk_i);
        vectors++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL read_pulse_end: got valid/ready=%b, required 01", {rsp_valid_o, cmd_ready_o});
        end
        repeat (2) @(negedge clk_i);
        vectors++;
        if (rsp_dat_o !== 32'h12345678) begin
            miscompares++;
            $display("FAIL read_dat_hold: got %h, required 12345678", rsp_dat_o);
        end
    endtask

    task automatic test_err_priority();
        int lat;
        rd_data = 32'hCAFEF00D;
        term_q.push_back(T_ERRACK);
        send_cmd(1'b0, 32'hC, 4'h3, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_rsp(lat);
        vectors++;
        if ({rsp_err_o, rsp_dat_o} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL err_priority: got err=%b dat=%h, required err=1 dat=0", rsp_err_o, rsp_dat_o);
        end
    endtask

    task automatic test_retry();
        int lat;
        rd_data = 32'hA5A50001;
        term_q.push_back(T_RTY); term_q.push_back(T_RTY); term_q.push_back(T_ACK);
        send_cmd(1'b0, 32'h10, 4'hF, 32'h0, 32'hA5A50001, 1'b0, 1'b0);
        wait_rsp(lat);
        vectors++;
        if ({phases, gap_cycles} !== {32'd3, 32'd2}) begin
            miscompares++;
            $display("FAIL retry_ok_phases: got phases=%0d gaps=%0d, required 3 and 2", phases, gap_cycles);
        end
        for (int i = 0; i < 4; i++) term_q.push_back(T_RTY);
        send_cmd(1'b1, 32'h14, 4'h1, 32'h55, 32'h0, 1'b1, 1'b0);
        wait_rsp(lat);
        vectors++;
        if ({phases, gap_cycles, rsp_err_o} !== {32'd4, 32'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL retry_exhaust: got phases=%0d gaps=%0d err=%b, required 4 3 1", phases, gap_cycles, rsp_err_o);
        end
    endtask

    task automatic test_stray();
        stray = 1'b1;
        repeat (3) @(negedge clk_i);
        vectors++;
        if ({cmd_ready_o, wb_cyc_o, rsp_valid_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL stray_term_idle: got ready/cyc/valid=%b, required 100", {cmd_ready_o, wb_cyc_o, rsp_valid_o});
        end
        stray = 1'b0;
        @(negedge clk_i);
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        term_q.push_back(T_HANG);
        send_cmd(1'b0, 32'h20, 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
        wait_rsp(lat);
        vectors++;
        if ({cyc_high, rsp_err_o, rsp_timeout_o, wb_cyc_o} !== {32'd16, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_rsp: got cyc_high=%0d err=%b to=%b cyc=%b, required 16 1 1 0",
                     cyc_high, rsp_err_o, rsp_timeout_o, wb_cyc_o);
        end
        @(negedge clk_i);
        vectors++;
        if (cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_ready: got cmd_ready_o=%b, required 1", cmd_ready_o);
        end
        term_q.delete();
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        int lat;
        term_q.push_back(T_HANG);
        send_cmd(1'b0, 32'h30, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (!(accepted && wb_cyc_o && !wb_stb_o) && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        vectors++;
        if ({wb_cyc_o, wb_stb_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_reach_wait: got cyc/stb=%b, required 10", {wb_cyc_o, wb_stb_o});
        end
        #2 rst_n_i = 1'b0;
        #1;
        vectors++;
        if ({wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o} !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_reset_async: got cyc/stb/vld/rdy=%b, required 0001",
                     {wb_cyc_o, wb_stb_o, rsp_valid_o, cmd_ready_o});
        end
        exp_q.delete();
        term_q.delete();
        inflight = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rd_data = 32'h0BADF00D;
        term_q.push_back(T_ACK);
        send_cmd(1'b0, 32'h34, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
        wait_rsp(lat);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL mid_after_release: got latency %0d, required 3", lat);
        end
    endtask

    initial begin
        test_reset();
        test_write_stall();
        test_read();
        test_err_priority();
        test_retry();
        test_stray();
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        repeat (3) @(negedge clk_i);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
